// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Writeback select, 32x32 register file with two combinational
//            read ports, forwarding outputs and a retired-write counter.
//            Define WB_BYPASS_EN to compile in the same-cycle write-through.
// Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         wb_mem_data,
  input  logic [DATA_W-1:0]         wb_alu_data,
  input  logic [$clog2(NREG)-1:0]   wb_rd,
  input  logic                      wb_sel,
  input  logic                      wb_en,
  input  logic [$clog2(NREG)-1:0]   rs_addr,
  input  logic [$clog2(NREG)-1:0]   rt_addr,
  output logic [DATA_W-1:0]         rs_data,
  output logic [DATA_W-1:0]         rt_data,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      wb_fwd_valid,
  output logic [31:0]               wr_count
);

  localparam int c_AW = $clog2(NREG);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [31:0]       r_wr_count;
  logic              w_commit;
  logic [DATA_W-1:0] w_rs_arr;
  logic [DATA_W-1:0] w_rt_arr;

  assign wb_data      = wb_sel ? wb_mem_data : wb_alu_data;
  assign w_commit     = wb_en && (wb_rd != '0);
  assign wb_fwd_valid = w_commit;
  assign wr_count     = r_wr_count;

  // Reset clears every entry in one edge and wins over a concurrent commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= 32'd0;
    end else if (w_commit) begin
      r_regs[wb_rd] <= wb_data;
      r_wr_count    <= r_wr_count + 32'd1;
    end
  end

  // r0 is masked on read so it stays zero regardless of array contents.
  always_comb begin
    w_rs_arr = (rs_addr == c_AW'(0)) ? '0 : r_regs[rs_addr];
    w_rt_arr = (rt_addr == c_AW'(0)) ? '0 : r_regs[rt_addr];
  end

  always_comb begin
    rs_data = w_rs_arr;
    rt_data = w_rt_arr;
`ifdef WB_BYPASS_EN
    if (w_commit && (rs_addr == wb_rd)) rs_data = wb_data;
    if (w_commit && (rt_addr == wb_rd)) rt_data = wb_data;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed and randomized self-checking bench for wb_regfile.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_mem_data, wb_alu_data;
  logic [4:0]  wb_rd, rs_addr, rt_addr;
  logic        wb_sel, wb_en;
  logic [31:0] rs_data, rt_data, wb_data, wr_count;
  logic        wb_fwd_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_mem_data(wb_mem_data), .wb_alu_data(wb_alu_data),
    .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_en(wb_en),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_fwd_valid(wb_fwd_valid),
    .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic en,
                                           input logic [4:0] rd, input logic [31:0] v);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (en && rd == a) return v;
`endif
    return m_regs[a];
  endfunction

  // One clock: drive at negedge, check combinational outputs, then the edge.
  task automatic cyc(input logic r, input logic en, input logic sel, input logic [4:0] rd,
                     input logic [31:0] mem, input logic [31:0] alu,
                     input logic [4:0] rs, input logic [4:0] rt);
    logic [31:0] v;
    @(negedge clk);
    rst = r; wb_en = en; wb_sel = sel; wb_rd = rd;
    wb_mem_data = mem; wb_alu_data = alu; rs_addr = rs; rt_addr = rt;
    #1;
    v = sel ? mem : alu;
    chk("wb_data", wb_data, v);
    chk("wb_fwd_valid", {31'd0, wb_fwd_valid}, {31'd0, en && (rd != 5'd0)});
    chk("rs_data", rs_data, exp_read(rs, en, rd, v));
    chk("rt_data", rt_data, exp_read(rt, en, rd, v));
    @(posedge clk);
    #1;
    if (!r) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (en && rd != 5'd0) begin
      m_regs[rd] = v;
      m_cnt = m_cnt + 32'd1;
    end
    chk("wr_count", wr_count, m_cnt);
  endtask

  initial begin
    rst = 1'b0; wb_en = 1'b0; wb_sel = 1'b0; wb_rd = 5'd0;
    wb_mem_data = 32'd0; wb_alu_data = 32'd0; rs_addr = 5'd0; rt_addr = 5'd0;
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    // Array contents are unknown until the first reset edge.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_count", wr_count, 32'd0);

    // Reset drops a concurrent write and clears existing contents.
    cyc(1, 1, 0, 5'd5, 32'd0, 32'h1234, 5'd5, 5'd6);
    cyc(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    chk("r5_loaded", rs_data, 32'h1234);
    cyc(0, 1, 0, 5'd6, 32'd0, 32'h77, 5'd5, 5'd6);
    cyc(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd6);
    chk("r5_after_reset", rs_data, 32'd0);
    chk("r6_dropped", rt_data, 32'd0);
    chk("count_after_reset", wr_count, 32'd0);

    // Select and commit.
    cyc(1, 1, 1, 5'd7, 32'hDEADBEEF, 32'h11, 5'd7, 5'd8);
    cyc(1, 1, 0, 5'd8, 32'hDEADBEEF, 32'h11, 5'd7, 5'd8);
    cyc(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd8);
    chk("r7_mem", rs_data, 32'hDEADBEEF);
    chk("r8_alu", rt_data, 32'h11);
    chk("count_two", wr_count, 32'd2);

    // r0 protection, including a same-cycle read of r0.
    cyc(1, 1, 1, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0);
    cyc(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd7);
    chk("r0_zero", rs_data, 32'd0);
    chk("count_r0", wr_count, 32'd2);

    // Same-cycle hazard on r3.
    cyc(1, 1, 0, 5'd3, 32'd0, 32'hA, 5'd3, 5'd3);
    cyc(1, 1, 0, 5'd3, 32'd0, 32'hB, 5'd3, 5'd3);
    cyc(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3);
    chk("r3_after", rs_data, 32'hB);

    // Write disable.
    cyc(1, 0, 0, 5'd9, 32'd0, 32'h55, 5'd9, 5'd9);
    cyc(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd9);
    chk("r9_kept", rs_data, 32'd0);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.r_wr_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wr_count;
    m_cnt = 32'hFFFFFFFF;
    cyc(1, 1, 0, 5'd1, 32'd0, 32'hC0DE, 5'd1, 5'd2);
    chk("count_wrap", wr_count, 32'd0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic [4:0] rd, rs, rt;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      cyc(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom), rd,
          $urandom, $urandom, rs, rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and 32×32 register file for the five-stage pipeline. Consumes the MEM/WB pipeline register outputs (memory load data, ALU result, destination register) and selects the writeback value. Commits that value to the register file on the clock edge and serves the two combinational read ports used by the decode stage. Also exports the selected writeback value for EX-stage forwarding and keeps a retired-write counter.

## Interface
Parameters:
- `DATA_W`, default 32: register and data width.
- `NREG`, default 32: register count; address width is log2(NREG) = 5.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-low: sampled on posedge `clk`, asserted when 0.
- `wb_mem_data`  in  32  load data from MEM/WB (data A).
- `wb_alu_data`  in  32  ALU result from MEM/WB (data B).
- `wb_rd`  in  5  destination register from MEM/WB.
- `wb_sel`  in  1  1 = write `wb_mem_data`, 0 = write `wb_alu_data`.
- `wb_en`  in  1  register write enable for the instruction in WB.
- `rs_addr`  in  5  read port A address.
- `rt_addr`  in  5  read port B address.
- `rs_data`  out  32  read port A data, combinational.
- `rt_data`  out  32  read port B data, combinational.
- `wb_data`  out  32  selected writeback value, combinational, for forwarding.
- `wb_fwd_valid`  out  1  `wb_en & (wb_rd != 0)`, combinational.
- `wr_count`  out  32  registered count of committed register writes.

## Operation
- Writeback select: `wb_data = wb_sel ? wb_mem_data : wb_alu_data`. Pure mux; no arithmetic.
- Commit: on posedge with `rst`=1, `wb_en`=1 and `wb_rd`≠0, `regs[wb_rd] <= wb_data`, and `wr_count <= wr_count + 1`.
- `wr_count` wraps from 0xFFFFFFFF to 0 with no flag.
- Register 0 is hardwired to zero:
  - A write to r0 is discarded and does not increment `wr_count`.
  - A read of r0 always returns 0, including through the bypass.
- `wb_en`=0: no register changes and no count increment. `wb_rd`/`wb_sel`/data are don't-care, but `wb_data` still reflects the mux.
- Reads: `rs_data = regs[rs_addr]` and `rt_data = regs[rt_addr]`, subject to the bypass rule under Configuration.
- Both read ports may address the same register, including the one being written; each port resolves independently.
- Reset (`rst`=0 at posedge):
  - All `NREG` registers clear to 0 in that single cycle.
  - `wr_count` clears to 0.
  - Any concurrent `wb_en` write is dropped; reset has priority.
  - Applies identically mid-operation.
- Reset values of outputs after the reset edge, for any address: `rs_data`=0, `rt_data`=0, `wr_count`=0. `wb_data` and `wb_fwd_valid` follow their inputs combinationally.

## Timing
- Write latency: value presented at edge N is readable from the array after edge N. With `WB_BYPASS_EN`, it is also visible before edge N on the read ports.
- Read latency: 0 cycles (combinational from address and array state).
- `wr_count` updates on the same edge as the commit.
- No handshake and no stall input. One write per cycle, every cycle, in lockstep with MEM/WB.
- Single clock domain. No multicycle paths. The critical path is `rs_addr` → array mux → bypass mux → `rs_data`.

## Configuration
- Macro `WB_BYPASS_EN` (define to compile in the internal write-through bypass).
- Defined: if `wb_en`=1, `wb_rd`≠0 and `rs_addr`==`wb_rd`, then `rs_data` = `wb_data` in the same cycle. Same rule for `rt`. This resolves the WB→ID hazard without a stall.
- Not defined: read ports return array contents only. A same-cycle read of the register being written returns the old value; the new value appears after the edge. The hazard unit must then stall one cycle.
- `wb_data`, `wb_fwd_valid`, `wr_count` and r0 behaviour are identical in both builds.

## Test plan
- Reset: hold `rst`=0 for one edge after writing r5=0x1234. Then `rs_addr`=5 → `rs_data`=0, `wr_count`=0. A write with `wb_en`=1 during the reset edge is not committed.
- Select and commit:
  - `wb_sel`=1, mem=0xDEADBEEF, alu=0x11, rd=7, `wb_en`=1, one edge → r7=0xDEADBEEF, `wr_count`=1.
  - `wb_sel`=0 to rd=8 → r8=0x11, `wr_count`=2.
- r0 protection: write 0xFFFFFFFF to rd=0 with `wb_en`=1 → `rs_addr`=0 reads 0, `wb_fwd_valid`=0, `wr_count` unchanged.
- Same-cycle hazard: r3 holds 0xA, write 0xB to r3 with `rs_addr`=`rt_addr`=3 before the edge.
  - With `WB_BYPASS_EN`: both ports read 0xB.
  - Without it: both read 0xA before the edge and 0xB after.
- Write disable: `wb_en`=0, rd=9, data=0x55 → r9 keeps its prior value (0 after reset), `wr_count` unchanged, `wb_data`=0x55.
- Counter wrap: preload via 2^32−1 writes (or force) `wr_count`=0xFFFFFFFF, then one valid write to r1 → `wr_count`=0.
